// File: rtl/control_unit_pkg.sv
// Shared definitions for the NanoRisc control unit: opcodes, ALU op codes
// and the packed bundle of datapath control signals.
package control_unit_pkg;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_SUB    = 3'b001;
   localparam logic [2:0] OP_MUL    = 3'b010;
   localparam logic [2:0] OP_LOAD   = 3'b011;
   localparam logic [2:0] OP_STORE  = 3'b100;
   localparam logic [2:0] OP_BRANCH = 3'b101;
   localparam logic [2:0] OP_HALT   = 3'b110;
   localparam logic [2:0] OP_SEND   = 3'b111;

   localparam logic [1:0] ULA_ADD  = 2'd0;
   localparam logic [1:0] ULA_SUB  = 2'd1;
   localparam logic [1:0] ULA_MUL  = 2'd2;
   localparam logic [1:0] ULA_PASS = 2'd3;

   typedef struct packed {
      logic       pc_write;
      logic       reg_write;
      logic       is_send;
      logic       is_branch;
      logic [1:0] ula_op;
      logic       mem_write;
      logic       mem_read;
      logic       reg_mem_write;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/control_unit_decoder.sv
// Pure combinational opcode-to-control decode; every opcode value is defined.
module control_unit_decoder
   import control_unit_pkg::*;
(
   input  logic [2:0] opcode,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = CTRL_IDLE;
      unique case (opcode)
         OP_ADD: begin
            ctrl.pc_write  = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.ula_op    = ULA_ADD;
         end
         OP_SUB: begin
            ctrl.pc_write  = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.ula_op    = ULA_SUB;
         end
         OP_MUL: begin
            ctrl.pc_write  = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.ula_op    = ULA_MUL;
         end
         OP_LOAD: begin
            // Address is formed with ADD; write-back takes memory data.
            ctrl.pc_write      = 1'b1;
            ctrl.reg_write     = 1'b1;
            ctrl.ula_op        = ULA_ADD;
            ctrl.mem_read      = 1'b1;
            ctrl.reg_mem_write = 1'b1;
         end
         OP_STORE: begin
            ctrl.pc_write  = 1'b1;
            ctrl.ula_op    = ULA_ADD;
            ctrl.mem_write = 1'b1;
         end
         OP_BRANCH: begin
            // Compare via SUB; the datapath applies the condition.
            ctrl.pc_write  = 1'b1;
            ctrl.is_branch = 1'b1;
            ctrl.ula_op    = ULA_SUB;
         end
         OP_HALT: begin
            ctrl.ula_op = ULA_PASS;
         end
         OP_SEND: begin
            ctrl.pc_write = 1'b1;
            ctrl.is_send  = 1'b1;
            ctrl.ula_op   = ULA_PASS;
         end
         default: ctrl = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// NanoRisc control unit: opcode decode, sticky halt state and output gating.
// Define CU_REGOUT_EN to register all eight control outputs (1-cycle latency).
module control_unit
   import control_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       isSend,
   output logic       isBranch,
   output logic [1:0] ULAOp,
   output logic       MemWrite,
   output logic       MemRead,
   output logic       RegMemWrite,
   output logic       halted
);

   ctrl_t dec_ctrl;
   ctrl_t out_ctrl;
   logic  halted_q;
   logic  halted_d;

   control_unit_decoder u_decoder (
      .opcode (opcode),
      .ctrl   (dec_ctrl)
   );

   // Halt state register; the state is visible directly on the halted port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   always_comb begin
      halted_d = halted_q;
      if (!halted_q && (opcode == OP_HALT)) begin
         halted_d = 1'b1;
      end
   end

`ifdef CU_REGOUT_EN
   ctrl_t ctrl_q;
   ctrl_t ctrl_d;

   always_comb begin
      ctrl_d = halted_q ? CTRL_IDLE : dec_ctrl;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= CTRL_IDLE;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   // The halting edge itself must already silence the freshly captured value.
   always_comb begin
      out_ctrl = halted_q ? CTRL_IDLE : ctrl_q;
   end
`else
   always_comb begin
      out_ctrl = halted_q ? CTRL_IDLE : dec_ctrl;
   end
`endif

   always_comb begin
      PCWrite     = out_ctrl.pc_write;
      RegWrite    = out_ctrl.reg_write;
      isSend      = out_ctrl.is_send;
      isBranch    = out_ctrl.is_branch;
      ULAOp       = out_ctrl.ula_op;
      MemWrite    = out_ctrl.mem_write;
      MemRead     = out_ctrl.mem_read;
      RegMemWrite = out_ctrl.reg_mem_write;
      halted      = halted_q;
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; control bits packed as
// {PCWrite,RegWrite,isSend,isBranch,ULAOp[1:0],MemWrite,MemRead,RegMemWrite}.
module tb_control_unit;

   logic       clk;
   logic       rst_n;
   logic [2:0] opcode;
   logic       PCWrite, RegWrite, isSend, isBranch;
   logic [1:0] ULAOp;
   logic       MemWrite, MemRead, RegMemWrite, halted;

   int n_checks;
   int n_errors;

   // Hand-computed decode vectors
   localparam logic [8:0] V_ADD    = 9'b1_1_0_0_00_0_0_0;
   localparam logic [8:0] V_SUB    = 9'b1_1_0_0_01_0_0_0;
   localparam logic [8:0] V_MUL    = 9'b1_1_0_0_10_0_0_0;
   localparam logic [8:0] V_LOAD   = 9'b1_1_0_0_00_0_1_1;
   localparam logic [8:0] V_STORE  = 9'b1_0_0_0_00_1_0_0;
   localparam logic [8:0] V_BRANCH = 9'b1_0_0_1_01_0_0_0;
   localparam logic [8:0] V_HALT   = 9'b0_0_0_0_11_0_0_0;
   localparam logic [8:0] V_SEND   = 9'b1_0_1_0_11_0_0_0;
   localparam logic [8:0] V_ZERO   = 9'b0;

   logic [8:0] exp_tab [8];

   control_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .PCWrite     (PCWrite),
      .RegWrite    (RegWrite),
      .isSend      (isSend),
      .isBranch    (isBranch),
      .ULAOp       (ULAOp),
      .MemWrite    (MemWrite),
      .MemRead     (MemRead),
      .RegMemWrite (RegMemWrite),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] ctrl_vec();
      return {PCWrite, RegWrite, isSend, isBranch, ULAOp, MemWrite, MemRead, RegMemWrite};
   endfunction

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_both(input string tag, input logic [8:0] exp_ctrl, input logic exp_halt);
      check({tag, "_ctrl"}, ctrl_vec(), exp_ctrl);
      check({tag, "_halted"}, {8'b0, halted}, {8'b0, exp_halt});
      if (MemRead && MemWrite) check({tag, "_memrw_excl"}, 9'd1, 9'd0);
      if (RegMemWrite && !MemRead) check({tag, "_rmw_needs_mr"}, 9'd1, 9'd0);
   endtask

   // Drive opcode just after the falling edge so settling is clear of posedge.
   task automatic step_neg(input logic [2:0] op);
      @(negedge clk);
      opcode = op;
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_tab[0] = V_ADD;   exp_tab[1] = V_SUB;
      exp_tab[2] = V_MUL;   exp_tab[3] = V_LOAD;
      exp_tab[4] = V_STORE; exp_tab[5] = V_BRANCH;
      exp_tab[6] = V_HALT;  exp_tab[7] = V_SEND;

      rst_n  = 1'b0;
      opcode = 3'b000;
      #2;
`ifdef CU_REGOUT_EN
      check_both("reset", V_ZERO, 1'b0);
      repeat (2) @(posedge clk);
      step_neg(3'b000);
      rst_n = 1'b1;
      check_both("after_release", V_ZERO, 1'b0);

      opcode = 3'b010;
      @(posedge clk); #1;
      check_both("reg_mul", V_MUL, 1'b0);
      opcode = 3'b111;
      @(posedge clk); #1;
      check_both("reg_send", V_SEND, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 6) continue;
         step_neg(3'(i));
         check_both($sformatf("reg_hold_%0d", i), (i == 0) ? V_SEND : exp_tab[i-1 == 6 ? 5 : i-1], 1'b0);
         @(posedge clk); #1;
         check_both($sformatf("reg_op_%0d", i), exp_tab[i], 1'b0);
      end

      step_neg(3'b110);
      @(posedge clk); #1;
      check_both("reg_halt_edge", V_ZERO, 1'b1);
      opcode = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      check_both("reg_halted_add", V_ZERO, 1'b1);

      #2 rst_n = 1'b0;
      #1;
      check_both("reg_reset_mid_halt", V_ZERO, 1'b0);
      step_neg(3'b000);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_both("reg_resume_add", V_ADD, 1'b0);
`else
      check_both("reset_comb_add", V_ADD, 1'b0);
      step_neg(3'b000);
      rst_n = 1'b1;
      #1;
      check_both("after_release", V_ADD, 1'b0);

      // Combinational sweep of all opcodes within one low phase of the clock.
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         opcode = 3'(i);
         #0.5;
         check_both($sformatf("decode_%0d", i), exp_tab[i], 1'b0);
      end
      opcode = 3'b000;

      step_neg(3'b010);
      check_both("mul", V_MUL, 1'b0);
      @(posedge clk); #1;
      check_both("mul_after_edge", V_MUL, 1'b0);
      step_neg(3'b111);
      check_both("send", V_SEND, 1'b0);
      step_neg(3'b011);
      check_both("load", V_LOAD, 1'b0);
      step_neg(3'b100);
      check_both("store", V_STORE, 1'b0);
      step_neg(3'b101);
      check_both("branch", V_BRANCH, 1'b0);

      step_neg(3'b110);
      check_both("halt_cycle", V_HALT, 1'b0);
      @(posedge clk); #1;
      check_both("halt_edge", V_ZERO, 1'b1);
      step_neg(3'b000);
      check_both("halted_add", V_ZERO, 1'b1);
      step_neg(3'b011);
      check_both("halted_load", V_ZERO, 1'b1);
      step_neg(3'b111);
      check_both("halted_send", V_ZERO, 1'b1);
      step_neg(3'b000);
      @(posedge clk); #1;
      check_both("still_halted", V_ZERO, 1'b1);

      // Reset mid-halt, away from any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check_both("reset_mid_halt", V_ADD, 1'b0);
      #1 rst_n = 1'b1;
      #1;
      check_both("resume_add", V_ADD, 1'b0);
      @(posedge clk); #1;
      check_both("resume_after_edge", V_ADD, 1'b0);

      // HALT presented during reset must not latch.
      step_neg(3'b110);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_both("halt_in_reset", V_HALT, 1'b0);
      step_neg(3'b001);
      rst_n = 1'b1;
      #1;
      check_both("sub_after_reset", V_SUB, 1'b0);
      @(posedge clk); #1;
      check_both("sub_after_edge", V_SUB, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction decoder and sequencing control for the NanoRisc core. It maps the 3-bit opcode of the current instruction onto the datapath control signals: PC update, register-file write, ALU (ULA) operation, memory read/write, write-back source, branch and send. It also tracks a sticky halt state that freezes the core. It sits between the instruction register and the datapath, and the datapath, register file, memory and I/O port consume its outputs.

## Interface
- No parameters.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- opcode  input  3  opcode field of the current instruction.
- PCWrite  output  1  PC may be updated this cycle.
- RegWrite  output  1  register-file write enable.
- isSend  output  1  drives register data onto the output port.
- isBranch  output  1  PC target comes from the branch path; the datapath applies the condition.
- ULAOp  output  2  ALU op: 0=ADD, 1=SUB, 2=MUL, 3=PASS.
- MemWrite  output  1  data-memory write enable.
- MemRead  output  1  data-memory read enable.
- RegMemWrite  output  1  write-back source: 1=memory data, 0=ALU result.
- halted  output  1  core is halted (sticky).

## Operation
- Decode, as PCWrite/RegWrite/isSend/isBranch/ULAOp/MemWrite/MemRead/RegMemWrite:
  - 000 ADD: 1/1/0/0/0/0/0/0
  - 001 SUB: 1/1/0/0/1/0/0/0
  - 010 MUL: 1/1/0/0/2/0/0/0
  - 011 LOAD: 1/1/0/0/0/0/1/1 (address = ADD)
  - 100 STORE: 1/0/0/0/0/1/0/0
  - 101 BRANCH: 1/0/0/1/1/0/0/0 (compare via SUB)
  - 110 HALT: 0/0/0/0/3/0/0/0
  - 111 SEND: 1/0/1/0/3/0/0/0
- Every opcode value is defined; no illegal-opcode path exists.
- halted flag: set on the rising edge where opcode=110 and halted=0. It stays set until rst_n is asserted.
- While halted=1, all outputs are forced to 0 (ULAOp=0) regardless of opcode, except halted itself.
- MemRead and MemWrite are never 1 simultaneously.
- RegMemWrite=1 only when MemRead=1.

## Timing
- Decode path (default build): combinational from opcode and halted. Outputs settle in the same cycle without any clock edge.
- halted: registered. It goes to 1 one rising edge after HALT is presented. Outputs are gated from that edge onward.
- The HALT cycle itself already drives PCWrite=0, so the PC never advances past HALT.
- Reset: asserting rst_n clears halted to 0 immediately (asynchronously). Outputs then reflect the current opcode decode (or 0 when registered).
- Reset mid-halt: the core resumes decoding on deassertion, with no extra cycle.
- HALT presented during reset has no effect.

## Configuration
- CU_REGOUT_EN defined: all eight control outputs are registered.
  - Value is the decode of the opcode at the previous rising edge, with 1-cycle latency.
  - Registered outputs are forced to 0 on reset and while halted.
  - halted timing is unchanged.
- CU_REGOUT_EN undefined: purely combinational decode as above.

## Structure
- Shared package control_unit_pkg holds:
  - opcode constants (OP_ADD..OP_SEND, 3 bits);
  - ULAOp constants (ULA_ADD, ULA_SUB, ULA_MUL, ULA_PASS);
  - a packed struct of the eight control signals.
- One sub-module, control_unit_decoder: pure combinational opcode-to-struct decode.
- The top level adds the halted register, output gating and the optional output register stage.

## Test plan
- MUL (opcode=010), not halted -> PCWrite=1, RegWrite=1, ULAOp=2, all others 0, same cycle (default build).
- SEND (opcode=111) -> PCWrite=1, isSend=1, ULAOp=3, RegWrite=MemWrite=MemRead=RegMemWrite=isBranch=0.
- Sweep LOAD/STORE/BRANCH (011/100/101):
  - LOAD -> MemRead=1, RegMemWrite=1, RegWrite=1;
  - STORE -> MemWrite=1, RegWrite=0;
  - BRANCH -> isBranch=1, ULAOp=1.
- HALT (110) for one edge, then ADD (000) -> halted=1 after the edge; all control outputs 0 while ADD is applied.
- Assert rst_n=0 mid-halt without a clock, then release, with opcode=000 -> halted=0 immediately; PCWrite=1, RegWrite=1, ULAOp=0.
- With CU_REGOUT_EN, apply 010 then 111 on consecutive edges -> MUL signals appear one edge after 010, SEND signals one edge after 111; outputs are 0 after reset.
